// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if -- bundle of the register-file write-back and read-port signals.
//
// Parameters
//   DATA_WIDTH : register data width
//   ADDR_WIDTH : register index width
//
// Signals
//   writeEnable_i / writeAddr_i / writeData_i : write-back request
//   readEnable1_i / readAddr1_i / readData1_o : read port 1
//   readEnable2_i / readAddr2_i / readData2_o : read port 2
//
// Modports
//   master : drives requests, receives read data (decode / write-back side)
//   slave  : the register file itself
// ---------------------------------------------------------------------------
interface regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  writeEnable_i;
  logic [ADDR_WIDTH-1:0] writeAddr_i;
  logic [DATA_WIDTH-1:0] writeData_i;
  logic                  readEnable1_i;
  logic [ADDR_WIDTH-1:0] readAddr1_i;
  logic [DATA_WIDTH-1:0] readData1_o;
  logic                  readEnable2_i;
  logic [ADDR_WIDTH-1:0] readAddr2_i;
  logic [DATA_WIDTH-1:0] readData2_o;

  modport master (
    output writeEnable_i, writeAddr_i, writeData_i,
    output readEnable1_i, readAddr1_i,
    output readEnable2_i, readAddr2_i,
    input  readData1_o, readData2_o
  );

  modport slave (
    input  writeEnable_i, writeAddr_i, writeData_i,
    input  readEnable1_i, readAddr1_i,
    input  readEnable2_i, readAddr2_i,
    output readData1_o, readData2_o
  );
endinterface

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 2**ADDR_WIDTH x DATA_WIDTH register file, one write port and
// two combinational read ports. Entry 0 is hardwired to zero.
//
// Ports
//   clk  : single clock, writes on the rising edge
//   rst  : asynchronous, active-low reset; clears every entry and forces
//          both read ports to zero while low
//   bus  : regfile_if.slave (write-back request, read ports 1 and 2)
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a read of the entry being written in
//                       the same cycle returns the incoming write data
//                       (write-first). When undefined the old stored value
//                       is returned and the new value appears next cycle.
// ---------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  write_ok_s;
  logic [DATA_WIDTH-1:0] read_data1_s;
  logic [DATA_WIDTH-1:0] read_data2_s;

  // A write qualifies only out of reset, when requested, and never to entry 0.
  assign write_ok_s = rst && bus.writeEnable_i && (bus.writeAddr_i != '0);

  // Next-state storage: copy, apply the qualified write, keep entry 0 at zero.
  always_comb begin
    regs_d = regs_q;
    if (write_ok_s) begin
      regs_d[bus.writeAddr_i] = bus.writeData_i;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = '0;
  end

  // Storage flops; the asynchronous reset clears every entry without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: zero when in reset, disabled or addressing entry 0.
  always_comb begin
    read_data1_s = '0;
    if (rst && bus.readEnable1_i && (bus.readAddr1_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (bus.writeEnable_i && (bus.writeAddr_i == bus.readAddr1_i)) begin
        read_data1_s = bus.writeData_i;
      end else begin
        read_data1_s = regs_q[bus.readAddr1_i];
      end
`else
      read_data1_s = regs_q[bus.readAddr1_i];
`endif
    end else begin
      read_data1_s = '0;
    end
  end

  // Read port 2: same rules as port 1, fully independent address.
  always_comb begin
    read_data2_s = '0;
    if (rst && bus.readEnable2_i && (bus.readAddr2_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (bus.writeEnable_i && (bus.writeAddr_i == bus.readAddr2_i)) begin
        read_data2_s = bus.writeData_i;
      end else begin
        read_data2_s = regs_q[bus.readAddr2_i];
      end
`else
      read_data2_s = regs_q[bus.readAddr2_i];
`endif
    end else begin
      read_data2_s = '0;
    end
  end

  // Reads are zero-latency so a decode stage can sample operands this cycle.
  assign bus.readData1_o = read_data1_s;
  assign bus.readData2_o = read_data2_s;

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 5, register index width (2**ADDR_WIDTH entries).
REQ-003 SHALL have port clk  input  1  single clock; all writes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port writeEnable_i  input  1  write-back request.
REQ-006 SHALL have port writeAddr_i  input  ADDR_WIDTH  write-back register index.
REQ-007 SHALL have port writeData_i  input  DATA_WIDTH  write-back data.
REQ-008 SHALL have port readEnable1_i  input  1  read port 1 request.
REQ-009 SHALL have port readAddr1_i  input  ADDR_WIDTH  read port 1 index.
REQ-010 SHALL have port readData1_o  output  DATA_WIDTH  read port 1 data.
REQ-011 SHALL have port readEnable2_i  input  1  read port 2 request.
REQ-012 SHALL have port readAddr2_i  input  ADDR_WIDTH  read port 2 index.
REQ-013 SHALL have port readData2_o  output  DATA_WIDTH  read port 2 data.

Function
REQ-014 SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits; entry 0 SHALL be hardwired zero.
REQ-015 SHALL write writeData_i into entry writeAddr_i on rising clk when rst=1, writeEnable_i=1, writeAddr_i!=0; write visible in storage one cycle later.
REQ-016 SHALL ignore writes with writeEnable_i=0 or writeAddr_i=0; storage unchanged.
REQ-017 SHALL drive read data combinationally (zero-cycle latency) from readEnableN_i/readAddrN_i, matching a decode stage that samples operands in the same cycle.
REQ-018 SHALL drive readDataN_o=0 when readEnableN_i=0, regardless of address.
REQ-019 SHALL drive readDataN_o=0 when readAddrN_i=0, even if a write to entry 0 is requested that cycle.
REQ-020 SHALL otherwise drive readDataN_o = stored entry readAddrN_i, subject to REQ-026.
REQ-021 SHALL let both read ports access any entries independently, including the same entry; same address SHALL yield identical data.
REQ-022 SHALL complete a write on every qualifying edge; back-to-back writes to the same entry SHALL leave the last value.

Reset
REQ-023 SHALL clear all entries to 0 immediately when rst falls, without waiting for clk.
REQ-024 SHALL drive readData1_o and readData2_o to 0 while rst=0, and SHALL ignore writes.
REQ-025 SHALL accept the first write at the first rising clk with rst=1; reset asserted mid-sequence SHALL discard all prior contents.

Configuration
REQ-026 SHALL honour macro REGFILE_BYPASS_EN: when defined, a read with readEnableN_i=1, readAddrN_i!=0, rst=1, writeEnable_i=1, writeAddr_i==readAddrN_i SHALL return writeData_i in the same cycle (write-first); when undefined, such a read SHALL return the old stored value and the new value appears the next cycle.

Verification
REQ-027 SHALL cover: rst=0 async pulse after writing 0x12345678 to r5 -> read r5 = 0x0 immediately, before any clk edge.
REQ-028 SHALL cover: write r0=0xFFFFFFFF, then read r0 on both ports -> 0x0.
REQ-029 SHALL cover: write r7=0xDEADBEEF, next cycle read port1 r7 enabled, port2 r7 disabled -> port1 0xDEADBEEF, port2 0x0.
REQ-030 SHALL cover: r3=0x11111111 stored, same cycle write r3=0x22222222 and read r3 -> 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; 0x22222222 next cycle in both builds.
REQ-031 SHALL cover: write r31=0xA5A5A5A5 and r1=0x5A5A5A5A on consecutive cycles, then read port1 r31, port2 r1 -> 0xA5A5A5A5 and 0x5A5A5A5A.
